// File: rtl/cmd_track_adder.sv
// -----------------------------------------------------------------------------
// cmd_track_adder
// Bit-serial recirculating command-register track with a windowed serial adder.
// One word circulates through a WORD_BITS-deep delay line, LSB first, one bit
// per clock. LOAD / ADD / CLEAR / NOP ops are requested through a valid/ready
// handshake and each one is applied to exactly one whole word circulation. The
// finished word is captured in parallel on word_q.
//
// Ports
//   CLOCK      in   bit-time clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   op_valid   in   op request
//   op_ready   out  high when no op is pending or executing
//   op_code    in   00 NOP (recirculate), 01 LOAD, 10 ADD, 11 CLEAR
//   op_inc     in   ADD: carry-in of 1 injected at bit ADD_LO
//   op_short   in   ADD: window ends at ALT_HI instead of ADD_HI
//   op_blk     in   force the top bit (WORD_BITS-1) of the op word to 0
//   din        in   LOAD serial data, sampled at bit time bt
//   addend     in   ADD serial addend, used only inside the add window
//   bt         out  current bit time 0..WORD_BITS-1
//   word_end   out  high when bt == WORD_BITS-1
//   dout       out  tail of the delay line (bit written one word ago)
//   busy       out  op word in progress
//   done       out  one-cycle pulse on the last bit of an op word
//   ovf        out  carry out of the add window end (registered)
//   word_q     out  parallel copy of the last completed op word
//   dbg_state  out  handshake FSM state (0 idle, 1 pending, 2 busy)
//
// Handshake: an op is transferred on a rising edge where op_valid and op_ready
// are both high; the op fields are latched on that edge and op_ready is low
// from the next cycle until the cycle after done. op_valid while op_ready is
// low is ignored, never queued.
// -----------------------------------------------------------------------------
module cmd_track_adder #(
   parameter int WORD_BITS = 29,
   parameter int ADD_LO    = 2,
   parameter int ADD_HI    = 28,
   parameter int ALT_HI    = 21,
   localparam int BT_W     = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1
) (
   input  logic                 CLOCK,
   input  logic                 rst,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [1:0]           op_code,
   input  logic                 op_inc,
   input  logic                 op_short,
   input  logic                 op_blk,
   input  logic                 din,
   input  logic                 addend,
   output logic [BT_W-1:0]      bt,
   output logic                 word_end,
   output logic                 dout,
   output logic                 busy,
   output logic                 done,
   output logic                 ovf,
   output logic [WORD_BITS-1:0] word_q,
   output logic [1:0]           dbg_state
);

   if (!(ADD_LO >= 0 && ADD_LO <= ALT_HI && ALT_HI <= ADD_HI &&
         ADD_HI <= WORD_BITS - 1 && WORD_BITS >= 2)) begin : g_bad_params
      $error("cmd_track_adder: need 0 <= ADD_LO <= ALT_HI <= ADD_HI <= WORD_BITS-1, WORD_BITS >= 2");
   end

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_ADD   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [BT_W-1:0] BT_LAST   = BT_W'(WORD_BITS - 1);
   localparam logic [BT_W-1:0] BT_ADD_LO = BT_W'(ADD_LO);
   localparam logic [BT_W-1:0] BT_ADD_HI = BT_W'(ADD_HI);
   localparam logic [BT_W-1:0] BT_ALT_HI = BT_W'(ALT_HI);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_BUSY = 2'd2
   } state_t;

   state_t                state, state_nx;
   logic [WORD_BITS-1:0]  line;
   logic                  carry;
   logic [1:0]            op_code_q;
   logic                  op_inc_q;
   logic                  op_short_q;
   logic                  op_blk_q;

   logic                  accept;
   logic                  start;
   logic                  u;
   logic                  w;
   logic                  cin;
   logic                  carry_nx;
   logic                  in_win;
   logic                  win_end;
   logic [BT_W-1:0]       win_hi;

   assign word_end  = (bt == BT_LAST);
   assign dout      = line[0];
   assign dbg_state = state;

   // ---------------------------------------------------------------------------
   // Handshake FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next state: an op accepted on the word_end edge goes straight to BUSY so
   // it owns the very next word.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (op_valid) state_nx = word_end ? S_BUSY : S_PEND;
         S_PEND:  if (word_end) state_nx = S_BUSY;
         S_BUSY:  if (word_end) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      op_ready = (state == S_IDLE);
      busy     = (state == S_BUSY);
      done     = (state == S_BUSY) && word_end;
      accept   = (state == S_IDLE) && op_valid;
      start    = word_end && ((state == S_PEND) || accept);
   end

   // ---------------------------------------------------------------------------
   // Serial datapath for the current bit time
   // ---------------------------------------------------------------------------
   always_comb begin
      u        = line[0];
      w        = line[0];
      carry_nx = 1'b0;
      win_hi   = op_short_q ? BT_ALT_HI : BT_ADD_HI;
      in_win   = busy && (op_code_q == OP_ADD) &&
                 (bt >= BT_ADD_LO) && (bt <= win_hi);
      win_end  = in_win && (bt == win_hi);
      // The increment replaces the running carry at the first window bit.
      cin      = (bt == BT_ADD_LO) ? op_inc_q : carry;

      if (busy) begin
         unique case (op_code_q)
            OP_LOAD:  u = din;
            OP_CLEAR: u = 1'b0;
            default:  u = line[0];
         endcase
      end

      if (in_win) begin
         w        = u ^ addend ^ cin;
         carry_nx = (u & addend) | (u & cin) | (addend & cin);
      end else begin
         w        = u;
      end

      // Block bit: top bit of an op word is written as 0 whatever the op.
      if (busy && op_blk_q && word_end) w = 1'b0;
   end

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         bt         <= '0;
         line       <= '0;
         carry      <= 1'b0;
         ovf        <= 1'b0;
         word_q     <= '0;
         op_code_q  <= OP_NOP;
         op_inc_q   <= 1'b0;
         op_short_q <= 1'b0;
         op_blk_q   <= 1'b0;
      end else begin
         bt   <= word_end ? '0 : bt + BT_W'(1);
         // New bit enters at the head; it reaches line[0] (dout) one word later.
         line <= {w, line[WORD_BITS-1:1]};

         // Carry only travels inside the window and is dropped at its end,
         // so it never wraps into bits above the window or into bit 0.
         carry <= (in_win && !win_end) ? carry_nx : 1'b0;

         if (accept) begin
            op_code_q  <= op_code;
            op_inc_q   <= op_inc;
            op_short_q <= op_short;
            op_blk_q   <= op_blk;
         end

         if (start)        ovf <= 1'b0;
         else if (win_end) ovf <= carry_nx;

         // On the done edge the shifted line is exactly the word just written.
         if (done) word_q <= {w, line[WORD_BITS-1:1]};
      end
   end

endmodule

// File: tb/tb_cmd_track_adder.sv
// -----------------------------------------------------------------------------
// tb_cmd_track_adder
// Self-checking bench for cmd_track_adder with default parameters. Expected
// words come from an arithmetic model of each op and are queued when the op
// is issued; a monitor pops and compares them after every done pulse.
// -----------------------------------------------------------------------------
module tb_cmd_track_adder;

   localparam int W   = 29;
   localparam int LO  = 2;
   localparam int HI  = 28;
   localparam int AHI = 21;

   localparam logic [1:0] C_NOP   = 2'b00;
   localparam logic [1:0] C_LOAD  = 2'b01;
   localparam logic [1:0] C_ADD   = 2'b10;
   localparam logic [1:0] C_CLEAR = 2'b11;

   logic          CLOCK = 1'b0;
   logic          rst   = 1'b1;
   logic          op_valid = 1'b0;
   logic          op_ready;
   logic [1:0]    op_code  = 2'b00;
   logic          op_inc   = 1'b0;
   logic          op_short = 1'b0;
   logic          op_blk   = 1'b0;
   logic          din      = 1'b0;
   logic          addend   = 1'b0;
   logic [4:0]    bt;
   logic          word_end;
   logic          dout;
   logic          busy;
   logic          done;
   logic          ovf;
   logic [W-1:0]  word_q;
   logic [1:0]    dbg_state;

   int            errors = 0;
   int            checks = 0;

   logic [W-1:0]  exp_q[$];
   logic          exp_ovf_q[$];
   logic [W-1:0]  model_line = '0;
   logic [W-1:0]  load_word  = '0;
   logic [W-1:0]  add_word   = '0;
   int            last_latency = 0;
   logic          first_busy = 1'b0;
   logic [4:0]    first_bt   = '0;
   logic          done_d     = 1'b0;

   cmd_track_adder #(.WORD_BITS(W), .ADD_LO(LO), .ADD_HI(HI), .ALT_HI(AHI)) dut (
      .CLOCK    (CLOCK),
      .rst      (rst),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_code  (op_code),
      .op_inc   (op_inc),
      .op_short (op_short),
      .op_blk   (op_blk),
      .din      (din),
      .addend   (addend),
      .bt       (bt),
      .word_end (word_end),
      .dout     (dout),
      .busy     (busy),
      .done     (done),
      .ovf      (ovf),
      .word_q   (word_q),
      .dbg_state(dbg_state)
   );

   // ---------------------------------------------------------------- clock
   always #5 CLOCK = ~CLOCK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Serial drivers: present the bit of the current bit time mid-cycle.
   always @(negedge CLOCK) begin
      din    = load_word[bt];
      addend = add_word[bt];
   end

   // ---------------------------------------------------------------- model
   function automatic logic [W-1:0] model_op(input logic [1:0] code,
                                             input logic inc, input logic sh,
                                             input logic blk,
                                             input logic [W-1:0] cur,
                                             input logic [W-1:0] lw,
                                             input logic [W-1:0] aw,
                                             output logic ov);
      longint unsigned mask, s, fc, fa;
      int hi, n;
      logic [W-1:0] r;
      ov = 1'b0;
      case (code)
         C_LOAD:  r = lw;
         C_CLEAR: r = '0;
         default: r = cur;
      endcase
      if (code == C_ADD) begin
         hi   = sh ? AHI : HI;
         n    = hi - LO + 1;
         mask = (64'd1 << n) - 64'd1;
         fc   = (64'(cur) >> LO) & mask;
         fa   = (64'(aw) >> LO) & mask;
         s    = fc + fa + 64'(inc);
         ov   = ((s >> n) & 64'd1) != 64'd0;
         r    = W'((64'(cur) & ~(mask << LO)) | ((s & mask) << LO));
      end
      if (blk) r[W-1] = 1'b0;
      return r;
   endfunction

   // ---------------------------------------------------------------- scoreboard
   always @(negedge CLOCK) begin
      if (rst) begin
         done_d = 1'b0;
      end else begin
         if (done_d) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_done: word_q=%h with no op outstanding", word_q);
            end else begin
               logic [W-1:0] e;
               logic eo;
               e  = exp_q.pop_front();
               eo = exp_ovf_q.pop_front();
               if (word_q !== e) begin
                  errors++;
                  $display("FAIL sb_word: word_q=%h expected %h", word_q, e);
               end
               checks++;
               if (ovf !== eo) begin
                  errors++;
                  $display("FAIL sb_ovf: ovf=%b expected %b", ovf, eo);
               end
            end
         end
         done_d = done;
      end
   end

   // ---------------------------------------------------------------- driver
   // Issues one op (optionally waiting for a given bit time first), queues its
   // expected word, then waits for done and one more cycle for word_q.
   task automatic send_op(input logic [1:0] code, input logic inc, input logic sh,
                          input logic blk, input logic [W-1:0] lw,
                          input logic [W-1:0] aw, input int at_bt);
      logic [W-1:0] e;
      logic eo;
      int n;
      int guard;
      load_word = lw;
      add_word  = aw;
      guard = 0;
      if (at_bt >= 0) begin
         while (int'(bt) != at_bt && guard < 4 * W) begin
            @(negedge CLOCK);
            guard++;
         end
      end
      guard = 0;
      while (op_ready !== 1'b1 && guard < 4 * W) begin
         @(negedge CLOCK);
         guard++;
      end
      checks++;
      if (op_ready !== 1'b1) begin
         errors++;
         $display("FAIL op_ready_timeout: op_ready=%b expected 1", op_ready);
      end
      e = model_op(code, inc, sh, blk, model_line, lw, aw, eo);
      model_line = e;
      exp_q.push_back(e);
      exp_ovf_q.push_back(eo);
      op_code  = code;
      op_inc   = inc;
      op_short = sh;
      op_blk   = blk;
      op_valid = 1'b1;
      @(negedge CLOCK);
      op_valid   = 1'b0;
      first_busy = busy;
      first_bt   = bt;
      n = 1;
      while (done !== 1'b1 && n < 3 * W) begin
         @(negedge CLOCK);
         n++;
      end
      last_latency = n;
      checks++;
      if (done !== 1'b1 || n < W || n > 2 * W - 1) begin
         errors++;
         $display("FAIL latency: cycles=%0d done=%b expected %0d..%0d", n, done, W, 2 * W - 1);
      end
      @(negedge CLOCK);
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset;
      @(negedge CLOCK);
      checks++;
      if (bt !== 5'd0 || op_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
          ovf !== 1'b0 || word_q !== '0 || dout !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: bt=%0d rdy=%b busy=%b done=%b ovf=%b word_q=%h dout=%b expected 0,1,0,0,0,0,0",
                  bt, op_ready, busy, done, ovf, word_q, dout);
      end
      rst = 1'b0;
      @(negedge CLOCK);
      checks++;
      if (bt !== 5'd1) begin
         errors++;
         $display("FAIL bt_count: bt=%0d expected 1", bt);
      end
   endtask

   task automatic test_load_replay;
      logic [W-1:0] v;
      v = 29'h00001234;
      send_op(C_LOAD, 1'b0, 1'b0, 1'b0, v, '0, -1);
      send_op(C_NOP, 1'b0, 1'b0, 1'b0, '0, '0, -1);
      checks++;
      if (word_q !== v) begin
         errors++;
         $display("FAIL load_word_q: word_q=%h expected %h", word_q, v);
      end
      // The idle word after the NOP replays the stored word on dout.
      for (int i = 0; i < W; i++) begin
         checks++;
         if (dout !== v[bt]) begin
            errors++;
            $display("FAIL replay_dout: bt=%0d dout=%b expected %b", bt, dout, v[bt]);
         end
         @(negedge CLOCK);
      end
   endtask

   task automatic test_reset_mid_add;
      int guard;
      int seen_done;
      load_word = '0;
      add_word  = 29'h0ABCDEF1;
      op_code   = C_ADD;
      op_inc    = 1'b1;
      op_short  = 1'b0;
      op_blk    = 1'b0;
      op_valid  = 1'b1;
      @(negedge CLOCK);
      op_valid = 1'b0;
      guard = 0;
      while (!(busy === 1'b1 && bt == 5'd10) && guard < 4 * W) begin
         @(negedge CLOCK);
         guard++;
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_add_busy: busy=%b expected 1", busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (word_q !== '0 || op_ready !== 1'b1 || busy !== 1'b0 || bt !== 5'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL mid_add_reset: word_q=%h rdy=%b busy=%b bt=%0d ovf=%b expected 0,1,0,0,0",
                  word_q, op_ready, busy, bt, ovf);
      end
      @(negedge CLOCK);
      rst = 1'b0;
      model_line = '0;
      exp_q.delete();
      exp_ovf_q.delete();
      seen_done = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge CLOCK);
         if (done === 1'b1) seen_done++;
         checks++;
         if (dout !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_dout: bt=%0d dout=%b expected 0", bt, dout);
         end
      end
      checks++;
      if (seen_done != 0 || word_q !== '0) begin
         errors++;
         $display("FAIL post_reset_done: done pulses=%0d word_q=%h expected 0,0", seen_done, word_q);
      end
   endtask

   task automatic test_add_inc;
      send_op(C_LOAD, 1'b0, 1'b0, 1'b0, 29'h00000004, '0, -1);
      send_op(C_ADD, 1'b1, 1'b0, 1'b0, '0, '0, -1);
      checks++;
      if (word_q !== 29'h00000008 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL add_inc: word_q=%h ovf=%b expected 00000008,0", word_q, ovf);
      end
   endtask

   task automatic test_add_short;
      send_op(C_LOAD, 1'b0, 1'b0, 1'b0, 29'h003FFFFC, '0, -1);
      send_op(C_ADD, 1'b1, 1'b1, 1'b0, '0, '0, -1);
      checks++;
      if (word_q !== 29'h00000000 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL add_short: word_q=%h ovf=%b expected 00000000,1", word_q, ovf);
      end
      // Bits above the short window keep their value while the window wraps.
      send_op(C_LOAD, 1'b0, 1'b0, 1'b0, 29'h1AFFFFFF, '0, -1);
      send_op(C_ADD, 1'b1, 1'b1, 1'b0, '0, '0, -1);
      checks++;
      if (word_q !== 29'h1AC00003 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL add_short_upper: word_q=%h ovf=%b expected 1ac00003,1", word_q, ovf);
      end
   endtask

   task automatic test_blk_word_end;
      send_op(C_LOAD, 1'b0, 1'b0, 1'b1, 29'h1FFFFFFF, '0, W - 1);
      checks++;
      if (word_q !== 29'h0FFFFFFF || ovf !== 1'b0) begin
         errors++;
         $display("FAIL blk_load: word_q=%h ovf=%b expected 0fffffff,0", word_q, ovf);
      end
      checks++;
      if (first_busy !== 1'b1 || first_bt !== 5'd0 || last_latency != W) begin
         errors++;
         $display("FAIL word_end_accept: busy=%b bt=%0d latency=%0d expected 1,0,%0d",
                  first_busy, first_bt, last_latency, W);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] e;
      logic eo;
      int accepts;
      int n;
      load_word = '0;
      add_word  = '0;
      e = model_op(C_NOP, 1'b0, 1'b0, 1'b0, model_line, '0, '0, eo);
      exp_q.push_back(e);
      exp_ovf_q.push_back(eo);
      op_code  = C_NOP;
      op_inc   = 1'b0;
      op_short = 1'b0;
      op_blk   = 1'b0;
      op_valid = 1'b1;
      accepts = 0;
      n = 0;
      while (done !== 1'b1 && n < 3 * W) begin
         if (op_valid && op_ready === 1'b1) accepts++;
         @(negedge CLOCK);
         n++;
      end
      checks++;
      if (accepts != 1 || done !== 1'b1) begin
         errors++;
         $display("FAIL held_valid_accepts: accepts=%0d done=%b expected 1,1", accepts, done);
      end
      @(negedge CLOCK);
      checks++;
      if (op_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_return: op_ready=%b expected 1", op_ready);
      end
      // op_valid is still high, so the second op is accepted on this edge.
      exp_q.push_back(e);
      exp_ovf_q.push_back(eo);
      @(negedge CLOCK);
      op_valid = 1'b0;
      checks++;
      if (op_ready !== 1'b0) begin
         errors++;
         $display("FAIL second_accept: op_ready=%b expected 0", op_ready);
      end
      n = 0;
      while (done !== 1'b1 && n < 3 * W) begin
         @(negedge CLOCK);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL second_done: done=%b expected 1", done);
      end
      @(negedge CLOCK);
      @(negedge CLOCK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: outstanding=%0d expected 0", exp_q.size());
      end
   endtask

   task automatic test_random;
      logic [1:0] code;
      for (int i = 0; i < 8; i++) begin
         code = 2'($urandom_range(0, 3));
         if (i % 2 == 1) code = C_ADD;
         send_op(code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), -1);
      end
      @(negedge CLOCK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_drain: outstanding=%0d expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_load_replay();
      test_reset_mid_add();
      test_add_inc();
      test_add_short();
      test_blk_word_end();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
